// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and one-shot sequencer in front of a single-port word memory.
// One transaction in flight at a time; completion is a registered pulse to the owning port.
module data_mem_arbiter #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MEM_WORDS_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0,
  input  logic              we0,
  input  logic [31:0]       addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,

  input  logic              req1,
  input  logic              we1,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,

  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_read_data,

  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                    r_state;
  state_e                    w_state_next;
  logic                      r_rr_ptr;
  logic                      r_owner;
  logic                      r_we;
  logic                      r_err;
  logic [MEM_WORDS_LOG2-1:0] r_widx;
  logic [DATA_W-1:0]         r_wdata;

  logic                      r_done0;
  logic                      r_done1;
  logic                      r_err0;
  logic                      r_err1;
  logic [DATA_W-1:0]         r_rdata0;
  logic [DATA_W-1:0]         r_rdata1;

  logic                      w_idle;
  logic                      w_gnt0;
  logic                      w_gnt1;
  logic                      w_sel_we;
  logic [31:0]               w_sel_addr;
  logic [DATA_W-1:0]         w_sel_wdata;
  logic                      w_sel_err;
  logic                      w_finish_now;

  logic [31:0]               w_mem_addr;
  logic [DATA_W-1:0]         w_mem_wdata;
  logic                      w_mem_write;
  logic                      w_mem_read;

  // On a tie the requester that did not win last time gets the grant.
  assign w_idle = (r_state == StIdle);
  assign w_gnt0 = w_idle && req0 && (!req1 || r_rr_ptr);
  assign w_gnt1 = w_idle && req1 && (!req0 || !r_rr_ptr);

  assign w_sel_we    = w_gnt1 ? we1    : we0;
  assign w_sel_addr  = w_gnt1 ? addr1  : addr0;
  assign w_sel_wdata = w_gnt1 ? wdata1 : wdata0;
  assign w_sel_err   = ((w_sel_addr >> (MEM_WORDS_LOG2 + 2)) != 32'd0) ||
                       (w_sel_addr[1:0] != 2'b00);

  // Errors and writes complete straight out of ISSUE; reads go through RESP.
  assign w_finish_now = (r_state == StIssue) && (r_err || r_we);

  always_comb begin
    w_state_next = r_state;
    w_mem_addr   = 32'd0;
    w_mem_wdata  = '0;
    w_mem_write  = 1'b0;
    w_mem_read   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_gnt0 || w_gnt1) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        if (!r_err) begin
          w_mem_addr = 32'(r_widx);
          if (r_we) begin
            w_mem_write = 1'b1;
            w_mem_wdata = r_wdata;
          end else begin
            w_mem_read = 1'b1;
          end
        end
        w_state_next = (!r_err && !r_we) ? StResp : StIdle;
      end
      StResp: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b1;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_widx   <= '0;
      r_wdata  <= '0;
    end else if (w_gnt0 || w_gnt1) begin
      r_rr_ptr <= w_gnt1;
      r_owner  <= w_gnt1;
      r_we     <= w_sel_we;
      r_err    <= w_sel_err;
      r_widx   <= w_sel_addr[MEM_WORDS_LOG2+1:2];
      r_wdata  <= w_sel_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      if (w_finish_now) begin
        if (r_owner) begin
          r_done1 <= 1'b1;
          r_err1  <= r_err;
          if (r_err) begin
            r_rdata1 <= '0;
          end
        end else begin
          r_done0 <= 1'b1;
          r_err0  <= r_err;
          if (r_err) begin
            r_rdata0 <= '0;
          end
        end
      end else if (r_state == StResp) begin
        if (r_owner) begin
          r_done1  <= 1'b1;
          r_rdata1 <= mem_read_data;
        end else begin
          r_done0  <= 1'b1;
          r_rdata0 <= mem_read_data;
        end
      end
    end
  end

  assign gnt0           = w_gnt0;
  assign gnt1           = w_gnt1;
  assign done0          = r_done0;
  assign done1          = r_done1;
  assign err0           = r_err0;
  assign err1           = r_err1;
  assign rdata0         = r_rdata0;
  assign rdata1         = r_rdata1;
  assign mem_addr       = w_mem_addr;
  assign mem_write_data = w_mem_wdata;
  assign mem_memwrite   = w_mem_write;
  assign mem_memread    = w_mem_read;
  assign busy           = !w_idle;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 256-word registered-read memory model.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, gnt0, done0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, gnt1, done1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [256];
  bit          loaded = 1'b0;

  data_mem_arbiter #(
    .DATA_W        (32),
    .MEM_WORDS_LOG2(8)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .req0          (req0),
    .we0           (we0),
    .addr0         (addr0),
    .wdata0        (wdata0),
    .gnt0          (gnt0),
    .done0         (done0),
    .rdata0        (rdata0),
    .err0          (err0),
    .req1          (req1),
    .we1           (we1),
    .addr1         (addr1),
    .wdata1        (wdata1),
    .gnt1          (gnt1),
    .done1         (done1),
    .rdata1        (rdata1),
    .err1          (err1),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_memwrite  (mem_memwrite),
    .mem_memread   (mem_memread),
    .mem_read_data (mem_read_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory preloads MEM[i] = i on the first edge, before any access can reach it.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
      loaded <= 1'b1;
    end else if (mem_memwrite && (mem_addr[31:8] == 24'd0)) begin
      mem[mem_addr[7:0]] <= mem_write_data;
    end
    if (mem_memread) mem_read_data <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_err1", err1, 0);
    chk("rst_memread", mem_memread, 0);
    chk("rst_memwrite", mem_memwrite, 0);
    chk("rst_memaddr", mem_addr, 0);
    rst = 1'b0;

    // Read of byte 0x10 by port 0
    @(posedge clk); #1; req0 = 1; we0 = 0; addr0 = 32'h10; #1;
    chk("rd0_gnt0", gnt0, 1);
    chk("rd0_gnt1", gnt1, 0);
    @(posedge clk); #1; req0 = 0; #1;
    chk("rd0_memread", mem_memread, 1);
    chk("rd0_memwrite", mem_memwrite, 0);
    chk("rd0_memaddr", mem_addr, 4);
    chk("rd0_busy_issue", busy, 1);
    @(posedge clk); #2;
    chk("rd0_done_early", done0, 0);
    @(posedge clk); #2;
    chk("rd0_done", done0, 1);
    chk("rd0_rdata", rdata0, 4);
    chk("rd0_err", err0, 0);
    chk("rd0_done1", done1, 0);
    chk("rd0_busy_idle", busy, 0);

    // Port 1 write then read-back of 0x20
    @(posedge clk); #1; req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'hDEADBEEF; #1;
    chk("wr1_gnt1", gnt1, 1);
    @(posedge clk); #1; req1 = 0; we1 = 0; #1;
    chk("wr1_memwrite", mem_memwrite, 1);
    chk("wr1_memread", mem_memread, 0);
    chk("wr1_memaddr", mem_addr, 8);
    chk("wr1_memwdata", mem_write_data, 32'hDEADBEEF);
    @(posedge clk); #2;
    chk("wr1_done1", done1, 1);
    chk("wr1_err1", err1, 0);
    chk("wr1_done0", done0, 0);
    @(posedge clk); #1; req1 = 1; we1 = 0; addr1 = 32'h20; #1;
    chk("rb1_gnt1", gnt1, 1);
    @(posedge clk); #1; req1 = 0; #1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rb1_done1", done1, 1);
    chk("rb1_rdata1", rdata1, 32'hDEADBEEF);
    chk("rb1_rdata0_held", rdata0, 4);

    // Both ports held after reset: grants alternate 0,1,0,1
    @(posedge clk); #1; rst = 1; #1;
    @(posedge clk); #1; rst = 0; #1;
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 32'h4; req1 = 1; we1 = 0; addr1 = 32'h8; #1;
    chk("rr_g0_gnt0", gnt0, 1);
    chk("rr_g0_gnt1", gnt1, 0);
    @(posedge clk); #2;
    chk("rr_busy1", busy, 1);
    chk("rr_nognt_busy", gnt1, 0);
    @(posedge clk); #2;
    chk("rr_busy2", busy, 1);
    @(posedge clk); #2;
    chk("rr_a_done0", done0, 1);
    chk("rr_a_rdata0", rdata0, 1);
    chk("rr_a_done1", done1, 0);
    chk("rr_a_busy", busy, 0);
    chk("rr_g1_gnt1", gnt1, 1);
    chk("rr_g1_gnt0", gnt0, 0);
    @(posedge clk); #2;
    chk("rr_busy4", busy, 1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rr_b_done1", done1, 1);
    chk("rr_b_rdata1", rdata1, 2);
    chk("rr_b_done0", done0, 0);
    chk("rr_g2_gnt0", gnt0, 1);
    chk("rr_g2_gnt1", gnt1, 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rr_c_done0", done0, 1);
    chk("rr_c_done1", done1, 0);
    chk("rr_g3_gnt1", gnt1, 1);
    chk("rr_g3_gnt0", gnt0, 0);
    @(posedge clk); #1; req0 = 0; req1 = 0; #1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rr_d_done1", done1, 1);
    chk("rr_d_done0", done0, 0);

    // Misaligned / out-of-range addresses
    @(posedge clk); #1; req0 = 1; we0 = 0; addr0 = 32'h402; #1;
    chk("e1_gnt0", gnt0, 1);
    @(posedge clk); #1; req0 = 0; #1;
    chk("e1_memread", mem_memread, 0);
    chk("e1_memwrite", mem_memwrite, 0);
    chk("e1_busy", busy, 1);
    @(posedge clk); #2;
    chk("e1_done0", done0, 1);
    chk("e1_err0", err0, 1);
    chk("e1_rdata0", rdata0, 0);
    @(posedge clk); #1; req0 = 1; we0 = 1; addr0 = 32'h400; wdata0 = 32'h12345678; #1;
    chk("e1_err_pulse", err0, 0);
    chk("e1_done_pulse", done0, 0);
    chk("e2_gnt0", gnt0, 1);
    @(posedge clk); #1; req0 = 0; we0 = 0; #1;
    chk("e2_memwrite", mem_memwrite, 0);
    chk("e2_memread", mem_memread, 0);
    @(posedge clk); #2;
    chk("e2_done0", done0, 1);
    chk("e2_err0", err0, 1);
    chk("e2_mem0", mem[0], 0);

    // Reset during ISSUE of a write to 0x30
    @(posedge clk); #1; req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hBAD0BAD0; #1;
    chk("rw_gnt0", gnt0, 1);
    @(posedge clk); #1; req0 = 0; we0 = 0; #1;
    chk("rw_memwrite", mem_memwrite, 1);
    rst = 1; #1;
    chk("rw_memwrite_drop", mem_memwrite, 0);
    chk("rw_memaddr_drop", mem_addr, 0);
    chk("rw_busy", busy, 0);
    @(posedge clk); #1; rst = 0; #1;
    chk("rw_nodone_a", done0, 0);
    @(posedge clk); #2;
    chk("rw_nodone_b", done0, 0);
    chk("rw_mem12", mem[12], 12);
    @(posedge clk); #1; req0 = 1; we0 = 0; addr0 = 32'h30; #1;
    chk("rw_rd_gnt0", gnt0, 1);
    @(posedge clk); #1; req0 = 0; #1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rw_rd_done0", done0, 1);
    chk("rw_rd_rdata0", rdata0, 12);

    // Port 1 withdraws its request while port 0 is being served
    @(posedge clk); #1; req0 = 1; we0 = 0; addr0 = 32'h0; #1;
    chk("wd_gnt0", gnt0, 1);
    @(posedge clk); #1; req0 = 0; req1 = 1; we1 = 0; addr1 = 32'h4; #1;
    chk("wd_gnt1_a", gnt1, 0);
    @(posedge clk); #1; req1 = 0; #1;
    chk("wd_gnt1_b", gnt1, 0);
    @(posedge clk); #2;
    chk("wd_done0", done0, 1);
    chk("wd_rdata0", rdata0, 0);
    chk("wd_gnt1_c", gnt1, 0);
    chk("wd_done1_a", done1, 0);
    @(posedge clk); #2;
    chk("wd_done1_b", done1, 0);
    chk("wd_busy", busy, 0);
    @(posedge clk); #2;
    chk("wd_done1_c", done1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port, word-indexed, 256-word data memory.
- Memory has a registered read and a synchronous write.
- Requester 0 is the core load/store unit; requester 1 is the debug/DMA loader.
- The block accepts one byte-addressed word request at a time, converts it to a word index, drives the memory strobes for exactly one cycle, and returns a completion pulse with read data or an error flag.

Parameters:
- DATA_W, 32, data width of requesters and memory.
- MEM_WORDS_LOG2, 8, log2 of memory depth in words; the valid byte range is 0 .. 4*2^MEM_WORDS_LOG2 - 1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 request; held with its command until gnt0.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  32  requester 0 byte address.
- wdata0  in  DATA_W  requester 0 write data.
- gnt0  out  1  requester 0 command accepted (combinational, single cycle).
- done0  out  1  requester 0 completion pulse (registered).
- rdata0  out  DATA_W  requester 0 read data, valid while done0.
- err0  out  1  requester 0 address error, valid while done0.
- req1, we1, addr1, wdata1, gnt1, done1, rdata1, err1: same as above for requester 1.
- mem_addr  out  32  word index to memory: {zeros, addr[MEM_WORDS_LOG2+1:2]}.
- mem_write_data  out  DATA_W  write data to memory.
- mem_memwrite  out  1  memory write strobe.
- mem_memread  out  1  memory read strobe.
- mem_read_data  in  DATA_W  memory registered read output.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, rr_ptr = 1.
  - All done/err/rdata and mem_* outputs = 0; busy = 0.
  - Any in-flight transaction is dropped with no done.
  - Strobes fall immediately, so a write not yet sampled by the memory is not committed.
- States: IDLE, ISSUE, RESP.
- IDLE, arbitration:
  - If exactly one req is high, that requester wins.
  - If both are high, the requester != rr_ptr wins. After reset, requester 0 wins the first tie.
  - gnt_w = 1 in the same cycle. The command (we, addr, wdata, owner) is latched, rr_ptr <= w, and next state = ISSUE.
  - gnt is never asserted outside IDLE.
- Address check at latch: err = (addr[31:MEM_WORDS_LOG2+2] != 0) or (addr[1:0] != 0).
- ISSUE, exactly one cycle:
  - err = 1: no strobe. Next state IDLE; done_owner = 1 and err_owner = 1 with rdata = 0 in the following cycle.
  - Write: mem_memwrite = 1, mem_addr and mem_write_data from the latch. Next state IDLE; done_owner = 1 in the following cycle.
  - Read: mem_memread = 1, mem_addr from the latch. Next state RESP.
- RESP, one cycle: rdata_owner <= mem_read_data; next state IDLE; done_owner = 1 in the following cycle.
- Latency, with gnt in cycle T:
  - Strobe in cycle T+1.
  - Write or error done in cycle T+2.
  - Read done in cycle T+3.
  - A new grant is possible in the same cycle done is high, because the state is IDLE then.
- Completion outputs:
  - done and err are one-cycle pulses.
  - rdata holds its last value until the next read completion for that port.
  - done goes only to the owner; the other port's outputs are unchanged.
- Memory outputs:
  - mem_memwrite and mem_memread are never high together.
  - Both are 0 outside ISSUE.
  - mem_addr and mem_write_data are 0 outside ISSUE.
- Request hold rule: a requester that drops req before gnt has not been served, and no done follows.
- Requester interface: at most one outstanding transaction per requester, and at most one in the whole block.

Test Plan:
- Reset, then req0 reads byte 0x10 with memory preloaded MEM[i] = i:
  - gnt0 at T, mem_memread = 1 and mem_addr = 4 at T+1.
  - done0 = 1, rdata0 = 4, err0 = 0 at T+3.
- req1 writes 0xDEADBEEF to 0x20, then req1 reads 0x20:
  - mem_memwrite at T+1 with mem_addr = 8, done1 at T+2.
  - The read returns rdata1 = 0xDEADBEEF.
- req0 and req1 both held continuously after reset, all reads:
  - Grant order 0, 1, 0, 1.
  - Each done goes to the correct port only; busy stays high between back-to-back grants except on the done/IDLE cycles.
- Error addresses:
  - req0 reads 0x402: err0 = 1, done0 at T+2, no strobe ever asserted.
  - req0 writes 0x400: same result, and memory is unchanged.
- Reset mid-operation: assert rst during ISSUE of a write to 0x30:
  - mem_memwrite drops immediately and no done follows.
  - A later read of 0x30 returns 12.
- req1 deasserted before its grant while req0 is busy:
  - gnt1 is never asserted and done1 stays 0.
